// File: rtl/tick_scheduler_if.sv
// Configuration, start/stop strobes and per-channel outputs of the tick scheduler.
// The master side drives configuration and strobes; the slave side is the scheduler.
interface tick_scheduler_if #(
    parameter int NCH = 4,
    parameter int PW  = 16
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [PW-1:0]  cfg_period;
    logic           cfg_periodic;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic           base_tick;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clkout;
    logic [NCH-1:0] active;

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_periodic, start, stop,
        input  base_tick, tick, clkout, active
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_periodic, start, stop,
        output base_tick, tick, clkout, active
    );
endinterface

// File: rtl/tick_scheduler.sv
// Shared prescaler producing a base tick, plus NCH independent one-shot/periodic
// channels, each emitting an expiry pulse and a square wave toggled on every expiry.
module tick_scheduler #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BASE_FREQ = 1000,
    parameter int PRESC     = CLK_FREQ / BASE_FREQ,
    parameter int NCH       = 4,
    parameter int PW        = 16
) (
    input  logic            clkin,
    input  logic            rst,
    tick_scheduler_if.slave bus
);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CHW1 = CHW + 1;
    localparam int PCW  = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PCW-1:0]  PCNT_LAST = PCW'(PRESC - 1);
    localparam logic [CHW1-1:0] NCH_LIM   = CHW1'(NCH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

    logic [PCW-1:0] pcnt_r;
    logic           base_tick_r;
    logic           cfg_valid_s;
    logic [NCH-1:0] tick_vec_s;
    logic [NCH-1:0] clkout_vec_s;
    logic [NCH-1:0] active_vec_s;

    // Writes addressed beyond the last channel are dropped here.
    assign cfg_valid_s = bus.cfg_we && ({1'b0, bus.cfg_ch} < NCH_LIM);

    // Free-running prescaler; base_tick_r marks the wrap from PRESC-1 to 0.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            pcnt_r      <= {PCW{1'b0}};
            base_tick_r <= 1'b0;
        end else if (pcnt_r == PCNT_LAST) begin
            pcnt_r      <= {PCW{1'b0}};
            base_tick_r <= 1'b1;
        end else begin
            pcnt_r      <= pcnt_r + PCW'(1);
            base_tick_r <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_t     state_r;
        ch_state_t     state_s;
        logic [PW-1:0] period_r;
        logic [PW-1:0] cnt_r;
        logic [PW-1:0] cnt_s;
        logic          periodic_r;
        logic          tick_r;
        logic          tick_s;
        logic          clkout_r;
        logic          clkout_s;
        logic          cfg_hit_s;

        assign cfg_hit_s = cfg_valid_s && (bus.cfg_ch == CHW'(i));

        // Period/mode registers; a same-edge start or reload still sees the old values.
        always_ff @(posedge clkin or negedge rst) begin
            if (!rst) begin
                period_r   <= {PW{1'b0}};
                periodic_r <= 1'b0;
            end else if (cfg_hit_s) begin
                period_r   <= bus.cfg_period;
                periodic_r <= bus.cfg_periodic;
            end else begin
                period_r   <= period_r;
                periodic_r <= periodic_r;
            end
        end

        // Channel state, counter and registered outputs.
        always_ff @(posedge clkin or negedge rst) begin
            if (!rst) begin
                state_r  <= IDLE;
                cnt_r    <= {PW{1'b0}};
                tick_r   <= 1'b0;
                clkout_r <= 1'b0;
            end else begin
                state_r  <= state_s;
                cnt_r    <= cnt_s;
                tick_r   <= tick_s;
                clkout_r <= clkout_s;
            end
        end

        // Next state: stop beats start, start beats counting, and a start edge never decrements.
        always_comb begin
            state_s  = state_r;
            cnt_s    = cnt_r;
            tick_s   = 1'b0;
            clkout_s = clkout_r;
            if (bus.stop[i]) begin
                state_s = IDLE;
            end else if (bus.start[i] && (period_r == {PW{1'b0}})) begin
                state_s = IDLE;
            end else if (bus.start[i]) begin
                cnt_s   = period_r;
                state_s = RUN;
            end else begin
                case (state_r)
                    RUN: begin
                        if (!base_tick_r) begin
                            cnt_s = cnt_r;
                        end else if (cnt_r == PW'(1)) begin
                            tick_s   = 1'b1;
                            clkout_s = ~clkout_r;
                            if (periodic_r && (period_r != {PW{1'b0}})) begin
                                cnt_s = period_r;
                            end else begin
                                state_s = IDLE;
                            end
                        end else if (cnt_r > PW'(1)) begin
                            cnt_s = cnt_r - PW'(1);
                        end else begin
                            // A zero count while running is unreachable; park the channel safely.
                            state_s = IDLE;
                        end
                    end
                    IDLE: begin
                        state_s = IDLE;
                    end
                    default: begin
                        state_s = IDLE;
                    end
                endcase
            end
        end

        assign tick_vec_s[i]   = tick_r;
        assign clkout_vec_s[i] = clkout_r;
        assign active_vec_s[i] = (state_r == RUN);
    end

    assign bus.base_tick = base_tick_r;
    assign bus.tick      = tick_vec_s;
    assign bus.clkout    = clkout_vec_s;
    assign bus.active    = active_vec_s;
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: a directed vector table, a mid-run reset sequence and a
// random phase, all checked every cycle against a deadline-based reference model.
module tb_tick_scheduler;
    localparam int PRESC = 10;
    localparam int NCH   = 4;
    localparam int PW    = 16;

    logic clkin = 1'b0;
    logic rst   = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    tick_scheduler_if #(.NCH(NCH), .PW(PW)) bus ();

    tick_scheduler #(.PRESC(PRESC), .NCH(NCH), .PW(PW)) dut (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    // Reference model: each running channel holds the absolute cycle of its next tick.
    bit             m_run [NCH];
    int             m_due [NCH];
    int             m_per [NCH];
    bit             m_pdc [NCH];
    bit             m_clk [NCH];
    logic [NCH-1:0] e_tick, e_clk, e_act;
    logic           e_base;

    typedef struct {
        int             pre;
        logic           we;
        logic [1:0]     ch;
        logic [PW-1:0]  per;
        logic           pdc;
        logic [NCH-1:0] st;
        logic [NCH-1:0] sp;
        logic           bt;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] ck;
        logic [NCH-1:0] ac;
    } vec_t;

    vec_t vt [21];

    function automatic int first_base(input int c);
        return ((c + PRESC - 1) / PRESC) * PRESC;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_run[k] = 1'b0; m_due[k] = 0; m_per[k] = 0; m_pdc[k] = 1'b0; m_clk[k] = 1'b0;
        end
        cyc = 0;
    endtask

    task automatic model_edge();
        cyc++;
        e_tick = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.stop[k]) begin
                m_run[k] = 1'b0;
            end else if (bus.start[k] && m_per[k] == 0) begin
                m_run[k] = 1'b0;
            end else if (bus.start[k]) begin
                m_run[k] = 1'b1;
                m_due[k] = first_base(cyc) + (m_per[k] - 1) * PRESC + 1;
            end else if (m_run[k] && m_due[k] == cyc) begin
                e_tick[k] = 1'b1;
                m_clk[k]  = !m_clk[k];
                if (m_pdc[k] && m_per[k] != 0) m_due[k] = cyc + m_per[k] * PRESC;
                else m_run[k] = 1'b0;
            end
        end
        if (bus.cfg_we && int'(bus.cfg_ch) < NCH) begin
            m_per[bus.cfg_ch] = int'(bus.cfg_period);
            m_pdc[bus.cfg_ch] = bus.cfg_periodic;
        end
        e_base = (cyc % PRESC == 0);
        for (int k = 0; k < NCH; k++) begin
            e_clk[k] = m_clk[k];
            e_act[k] = m_run[k];
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic drive_idle();
        bus.cfg_we = 1'b0; bus.cfg_ch = 2'd0; bus.cfg_period = 16'd0; bus.cfg_periodic = 1'b0;
        bus.start = 4'b0000; bus.stop = 4'b0000;
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
        model_edge();
        chk("base_tick", 16'(bus.base_tick), 16'(e_base));
        chk("tick",      16'(bus.tick),      16'(e_tick));
        chk("clkout",    16'(bus.clkout),    16'(e_clk));
        chk("active",    16'(bus.active),    16'(e_act));
        drive_idle();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_tick"},   16'(bus.tick),      16'd0);
        chk({name, "_clkout"}, 16'(bus.clkout),    16'd0);
        chk({name, "_active"}, 16'(bus.active),    16'd0);
        chk({name, "_base"},   16'(bus.base_tick), 16'd0);
    endtask

    initial begin
        // pre, we, ch, per, pdc, start, stop | base, tick, clkout, active
        vt[0]  = '{8,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        vt[1]  = '{0,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        vt[2]  = '{0,  1'b1, 2'd0, 16'd3, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        vt[3]  = '{0,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001};
        vt[4]  = '{27, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001};
        vt[5]  = '{0,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001};
        vt[6]  = '{29, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001};
        vt[7]  = '{0,  1'b1, 2'd1, 16'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001};
        vt[8]  = '{0,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0011};
        vt[9]  = '{16, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0011};
        vt[10] = '{0,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b0001};
        vt[11] = '{0,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0010, 4'b0000};
        vt[12] = '{7,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 4'b0000};
        vt[13] = '{0,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0001};
        vt[14] = '{19, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0001};
        vt[15] = '{9,  1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0011, 4'b0001};
        vt[16] = '{0,  1'b1, 2'd3, 16'd4, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0011, 4'b0001};
        vt[17] = '{0,  1'b0, 2'd0, 16'd0, 1'b0, 4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0011, 4'b1001};
        vt[18] = '{16, 1'b1, 2'd3, 16'd2, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0011, 4'b1001};
        vt[19] = '{20, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b1010, 4'b1001};
        vt[20] = '{19, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1001, 4'b0011, 4'b1001};

        drive_idle();
        model_reset();
        repeat (3) @(posedge clkin);
        #1;
        chk_all_zero("in_reset");
        rst = 1'b1;

        // Directed vectors: base tick cadence, periodic, one-shot, zero period, collisions, live reconfig.
        for (int i = 0; i < 21; i++) begin
            repeat (vt[i].pre) step();
            bus.cfg_we = vt[i].we; bus.cfg_ch = vt[i].ch; bus.cfg_period = vt[i].per;
            bus.cfg_periodic = vt[i].pdc; bus.start = vt[i].st; bus.stop = vt[i].sp;
            step();
            chk($sformatf("vec%0d_base", i),   16'(bus.base_tick), 16'(vt[i].bt));
            chk($sformatf("vec%0d_tick", i),   16'(bus.tick),      16'(vt[i].tk));
            chk($sformatf("vec%0d_clkout", i), 16'(bus.clkout),    16'(vt[i].ck));
            chk($sformatf("vec%0d_active", i), 16'(bus.active),    16'(vt[i].ac));
        end

        // Mid-run reset while ch0 sits at count 2: everything must drop before the next edge.
        repeat (14) step();
        chk("pre_reset_active", 16'(bus.active), 16'(4'b1001));
        #1 rst = 1'b0;
        #1 chk_all_zero("async_reset");
        model_reset();
        repeat (2) @(posedge clkin);
        #1;
        chk_all_zero("held_reset");
        rst = 1'b1;
        repeat (50) step();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bus.cfg_we       = ($urandom_range(0, 7) == 0);
            bus.cfg_ch       = 2'($urandom_range(0, 3));
            bus.cfg_period   = 16'($urandom_range(0, 4));
            bus.cfg_periodic = 1'($urandom_range(0, 1));
            for (int k = 0; k < NCH; k++) begin
                bus.start[k] = ($urandom_range(0, 19) == 0);
                bus.stop[k]  = ($urandom_range(0, 39) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
